// File: rtl/seis_a.sv
// seis_a: 3-bit binary-to-Gray converter with registered outputs.
// Inputs a (MSB), b, c (LSB) are sampled on every rising clk edge; x, y, z
// carry the reflected Gray code of the sampled value.
// Optional build macro SEISA_INPUT_SYNC_EN: when defined, each input passes
// through a 2-flop synchronizer (reset to 0) ahead of the Gray logic, giving
// a total latency of 3 cycles instead of 1. The port list is the same in both builds.
module seis_a #(
  parameter logic [2:0] INIT_XYZ = 3'b000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic x,
  output logic y,
  output logic z
);

  // Reflected Gray code of a 3-bit binary value: g = bin ^ (bin >> 1).
  function automatic logic [2:0] bin_to_gray(input logic [2:0] bin);
    bin_to_gray = {bin[2], bin[2] ^ bin[1], bin[1] ^ bin[0]};
  endfunction

  logic [2:0] abc;
  logic [2:0] xyz;

`ifdef SEISA_INPUT_SYNC_EN
  logic [2:0] sync_p0;
  logic [2:0] sync_p1;

  // Stages 0 and 1: two-flop synchronizer on each input bit, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 3'b000;
      sync_p1 <= 3'b000;
    end else begin
      sync_p0 <= {a, b, c};
      sync_p1 <= sync_p0;
    end
  end

  assign abc = sync_p1;
`else
  assign abc = {a, b, c};
`endif

  // Output stage: register the Gray code, forced to INIT_XYZ while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xyz <= INIT_XYZ;
    end else begin
      xyz <= bin_to_gray(abc);
    end
  end

  assign x = xyz[2];
  assign y = xyz[1];
  assign z = xyz[0];

endmodule

// File: tb/tb_seis_a.sv
// tb_seis_a: directed self-checking bench for seis_a (default INIT_XYZ = 000).
module tb_seis_a;

`ifdef SEISA_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  logic a, b, c;
  logic x, y, z;

  int checks = 0;
  int errors = 0;

  // Hand-computed Gray table indexed by abc.
  logic [2:0] gray_tab [8];
  logic [2:0] prev;
  logic [2:0] cur;

  seis_a dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .x    (x),
    .y    (y),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_abc(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  task automatic check_xyz(input string tag, input logic [2:0] exp);
    checks++;
    assert ({x, y, z} === exp) else begin
      errors++;
      $error("FAIL %s: xyz observed %b expected %b", tag, {x, y, z}, exp);
    end
  endtask

  task automatic check_one_bit(input string tag, input logic [2:0] p, input logic [2:0] q);
    int ones;
    ones = $countones(p ^ q);
    checks++;
    assert (ones === 1) else begin
      errors++;
      $error("FAIL %s: bits changed observed %0d expected 1 (%b -> %b)", tag, ones, p, q);
    end
  endtask

  initial begin
    gray_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    // Reset held with abc=101 for 3 cycles
    rst_n = 1'b0;
    set_abc(3'b101);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_xyz($sformatf("reset_hold_%0d", i), 3'b000);
    end
    rst_n = 1'b1;
    set_abc(3'b000);
    tick(LAT);
    check_xyz("after_release_000", 3'b000);

    // Exhaustive sweep with single-bit-change check on each step
    prev = 3'b000;
    for (int v = 0; v < 8; v++) begin
      set_abc(3'(v));
      tick(LAT);
      check_xyz($sformatf("sweep_%0d", v), gray_tab[v]);
      cur = {x, y, z};
      if (v > 0) check_one_bit($sformatf("adjacent_%0d", v), prev, cur);
      prev = cur;
    end

    // Wrap 111 -> 000
    set_abc(3'b000);
    tick(LAT);
    check_xyz("wrap_000", 3'b000);
    cur = {x, y, z};
    check_one_bit("adjacent_wrap", prev, cur);

    // Latency: change to 110 just after an edge, output holds until clocked
    set_abc(3'b110);
    #3;
    check_xyz("latency_hold", 3'b000);
    #2;
    tick(LAT);
    check_xyz("latency_update", 3'b101);

    // Input glitch between edges never reaches outputs
    set_abc(3'b011);
    #2;
    set_abc(3'b110);
    #2;
    check_xyz("glitch_hold", 3'b101);
    tick(LAT);
    check_xyz("glitch_after_edge", 3'b101);

    // Mid-run asynchronous reset pulse
    set_abc(3'b011);
    tick(LAT);
    check_xyz("pre_reset_011", 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check_xyz("async_reset_now", 3'b000);
    #4;
    rst_n = 1'b1;
    #1;
    check_xyz("released_before_edge", 3'b000);
    tick(LAT);
    check_xyz("post_reset_011", 3'b010);

`ifdef SEISA_INPUT_SYNC_EN
    // Synchronizer latency from reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    set_abc(3'b100);
    tick(1);
    check_xyz("sync_edge1", 3'b000);
    tick(1);
    check_xyz("sync_edge2", 3'b000);
    tick(1);
    check_xyz("sync_edge3", 3'b110);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seis_a.md
Name: seis_a

Overview:
- 3-bit binary-to-Gray-code converter with registered outputs.
- Inputs a (MSB), b, c (LSB) form a binary value; outputs x (MSB), y, z (LSB) carry its reflected Gray code one clock later.
- Leaf block used as a small sampled logic stage.
- Sits between asynchronous/bench-driven stimulus and downstream synchronous logic.

Parameters:
- INIT_XYZ, 3'b000, value loaded into {x,y,z} while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- a  input  1  binary input bit 2 (MSB).
- b  input  1  binary input bit 1.
- c  input  1  binary input bit 0 (LSB).
- x  output  1  Gray output bit 2 (MSB), registered.
- y  output  1  Gray output bit 1, registered.
- z  output  1  Gray output bit 0 (LSB), registered.

Behaviour:
- Single clock domain (clk). Reset rst_n is asynchronous and active-low.
- rst_n low: {x,y,z} = INIT_XYZ immediately, with no clock edge needed. Held for as long as rst_n is low.
- rst_n deasserts: the first rising clk edge with rst_n high captures the current inputs.
- Next-state function, combinational from the sampled inputs:
  - x_next = a
  - y_next = a XOR b
  - z_next = b XOR c
- Full mapping, abc -> xyz: 000->000, 001->001, 010->011, 011->010, 100->110, 101->111, 110->101, 111->100.
- Latency: exactly 1 clk cycle from input stable before a rising edge to outputs valid after that edge.
- Outputs hold their value between edges. Input glitches between edges never reach the outputs.
- No enable and no handshake: the block samples inputs on every rising edge.
- Reset asserted mid-operation: outputs go to INIT_XYZ asynchronously. Pending sampled data is discarded.
- Reset release coincident with a clock edge: that edge may or may not capture. The bench must not depend on that edge.
- Unknown (X) inputs propagate as X to the affected outputs only. No X-masking.
- All outputs are driven directly from flops; there is no combinational path from input to output.
- Adjacent-code property: any input step of ±1 (mod 8, including the 111->000 wrap) changes exactly one output bit.

Optional Feature:
- Macro: SEISA_INPUT_SYNC_EN.
- Defined:
  - a, b and c each pass through a 2-flop synchronizer (both flops reset to 0 by rst_n) before the Gray logic.
  - Total latency becomes 3 clk cycles.
  - During the first 2 cycles after reset release, the outputs reflect synchronizer contents (input 000 -> output 000, combined with INIT_XYZ only while in reset).
- Undefined:
  - No synchronizer; latency is 1 cycle as specified above.
  - Port list is identical in both builds.

Test Plan:
- Reset check: hold rst_n=0 with abc=101 for 3 cycles -> xyz=INIT_XYZ (000) throughout. Assert rst_n low between edges -> outputs go to 000 before the next edge.
- Exhaustive sweep: after reset, apply abc = 000,001,...,111, one value per clock -> xyz one cycle later = 000,001,011,010,110,111,101,100.
- Latency check: change abc from 000 to 110 just after an edge -> xyz stays 000 until the next rising edge, then becomes 101.
- Wrap/adjacency: apply abc 111 then 000 -> xyz 100 then 000 (one bit changes). Check single-bit change for all 8 consecutive steps.
- Mid-run reset: drive abc=011 so that xyz=010, then pulse rst_n low for half a cycle -> xyz=000 immediately. After release with abc=011 -> xyz=010 one edge later.
- With SEISA_INPUT_SYNC_EN: abc=100 applied after reset -> xyz=000 for 2 edges, then 110 on the 3rd edge.
